dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port byte-addressed data memory (16-bit big-endian words at addr, addr+1;
//  combinational read, write on posedge) between the pipeline MEM stage (CPU) and an
//  auxiliary requester (loader/debug, AUX).
//  - One access per cycle; CPU has fixed priority; a starvation counter forces AUX grants.
//  - Sits between the MEM stage/aux port and the data memory; drives stall to the hazard unit.
// PARAMETERS
//  ADDR_W       16  address width (byte address)
//  DATA_W       16  word width
//  AUX_MAX_WAIT 4   consecutive cycles AUX may be denied before a forced grant (>=1)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU access request, held until cpu_ack
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  byte address
//  cpu_wdata    in   DATA_W  write data
//  cpu_ack      out  1       1-cycle pulse: access completed previous edge
//  cpu_rdata    out  DATA_W  registered read data, valid with cpu_ack
//  cpu_stall    out  1       cpu_req & ~(CPU granted this cycle)
//  aux_req/aux_we/aux_addr/aux_wdata/aux_ack/aux_rdata   same as cpu_* for AUX
//  mem_wr_en    out  1       to memory wr_en
//  mem_rd_addr  out  ADDR_W  to memory read_add
//  mem_wr_addr  out  ADDR_W  to memory wr_add
//  mem_wdata    out  DATA_W  to memory data_in
//  mem_rdata    in   DATA_W  from memory data_out
//  err          out  1       misalign pulse (DMEM_ARB_ALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=ARB, starve_cnt=0, acks=0, rdata regs=0, err=0.
//    Grant muxing suppressed, mem_wr_en=0, mem addr/wdata=0.
//  - FSM {ARB, AUX_FORCE} in registered state; grant decode is combinational from state+reqs.
//    ARB: cpu_req -> grant CPU; else aux_req -> grant AUX; else idle.
//    ARB and aux_req denied: starve_cnt++; when starve_cnt==AUX_MAX_WAIT-1 and denied again,
//      next state=AUX_FORCE.
//    AUX_FORCE: grant AUX regardless of cpu_req (cpu_stall=1); starve_cnt<=0; next=ARB.
//    Any AUX grant clears starve_cnt; aux_req=0 clears starve_cnt.
//  - Granted cycle N: mem_* driven from granted requester (mem_rd_addr=mem_wr_addr=addr;
//    mem_wr_en=we). At edge N: write commits / mem_rdata captured into that rdata reg;
//    ack high during N+1 (latency 1).
//  - Requester that sees ack in N+1 with req still high is a new request, eligible in N+1
//    (back-to-back CPU = 1 access/cycle, ack every cycle).
//  - Non-granted rdata reg holds its value. Write acks leave rdata unchanged.
//  - Simultaneous CPU write and AUX read of same addr: CPU served first; AUX later sees new data.
//  - Address wrap: addr=0xFFFF uses byte 0xFFFF and wrapped 0x0000 (memory's concern; pass through).
//  - Reset mid-access: ack/rdata cleared immediately, no write after rst deasserts.
//    Requesters must re-issue.
// CONFIGURATION
//  DMEM_ARB_ALIGN_CHECK_EN defined: granted request with addr[0]=1 is not forwarded
//    (mem_wr_en=0); ack still pulses N+1, rdata unchanged, err pulses N+1.
//    Grant/starvation accounting is unchanged.
//  Undefined: odd addresses forwarded unchanged; err tied 0.
// STRUCTURE
//  Package dmem_arb_pkg: ADDR_W/DATA_W defaults, state encoding (ARB=1'b0, AUX_FORCE=1'b1),
//    requester index constants (REQ_CPU, REQ_AUX).
//  Sub-module dmem_arb_starve_ctr: saturating wait counter (inc/clr, hit flag at AUX_MAX_WAIT-1).
// TESTING
//  1 CPU read 0x0008, mem holds 0x000C -> cpu_ack at N+1, cpu_rdata=0x000C, mem_wr_en=0.
//  2 CPU write 0x0010<-0xBEEF, then CPU read 0x0010 next cycle -> ack both cycles, rdata=0xBEEF.
//  3 cpu_req & aux_req held continuously, AUX_MAX_WAIT=4 -> AUX granted every 5th cycle,
//    cpu_stall=1 only in that cycle.
//  4 Same-cycle CPU write 0x0020<-0x1234, AUX read 0x0020 -> CPU acked first, aux_rdata=0x1234.
//  5 rst low during granted write cycle -> no mem write, acks=0, starve_cnt=0 after release.
//  6 ALIGN_CHECK_EN: CPU write addr 0x0009 -> no mem_wr_en, cpu_ack+err at N+1.
//    Without macro: write passes through.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: default widths,
//   arbiter state encoding and requester index constants.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int AUX_MAX_WAIT_DEF = 4;

  typedef enum logic {
    ARB       = 1'b0,
    AUX_FORCE = 1'b1
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr
//   Saturating count of consecutive cycles the AUX requester was denied.
//   Ports:
//     clk, rst  clock / async active-low reset
//     inc       AUX denied this cycle
//     clr       AUX granted or not requesting (has priority over inc)
//     hit       count has reached MAX_WAIT-1
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] HIT_VAL = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  // Saturates at HIT_VAL: the arbiter leaves ARB on the next denial, so
  // counting further would carry no information.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != HIT_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the CPU MEM stage and an
//   auxiliary requester. CPU has fixed priority; AUX is force-granted after
//   AUX_MAX_WAIT consecutive denials. One access per cycle, ack one cycle
//   after the grant, read data registered per requester.
//   Ports:
//     clk, rst                      clock / async active-low reset
//     cpu_req/we/addr/wdata         CPU request (held until cpu_ack)
//     cpu_ack, cpu_rdata, cpu_stall CPU completion, read data, stall
//     aux_req/we/addr/wdata         AUX request (held until aux_ack)
//     aux_ack, aux_rdata            AUX completion, read data
//     mem_wr_en/rd_addr/wr_addr/wdata, mem_rdata   memory interface
//     err                           misaligned-access pulse
//   Build option: define DMEM_ARB_ALIGN_CHECK_EN to block odd-address
//   accesses and report them on err; otherwise err is tied 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int AUX_MAX_WAIT = AUX_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_e        state, state_nxt;
  logic              gnt_cpu, gnt_aux, gnt_any;
  logic              sel;
  logic              ctr_inc, ctr_clr, starve_hit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misalign;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(AUX_MAX_WAIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (ctr_inc),
    .clr (ctr_clr),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_nxt;
  end

  // Grants are gated by rst so nothing reaches the memory while reset is
  // asserted, even if requests are still high.
  always_comb begin
    gnt_cpu   = 1'b0;
    gnt_aux   = 1'b0;
    ctr_inc   = 1'b0;
    state_nxt = state;
    if (rst) begin
      case (state)
        ARB: begin
          if (cpu_req) begin
            gnt_cpu = 1'b1;
            if (aux_req) begin
              ctr_inc = 1'b1;
              if (starve_hit) state_nxt = AUX_FORCE;
            end
          end else if (aux_req) begin
            gnt_aux = 1'b1;
          end
        end
        AUX_FORCE: begin
          state_nxt = ARB;
          // AUX is required to hold its request, so the CPU fallback only
          // avoids wasting the slot if that is ever violated.
          if (aux_req)      gnt_aux = 1'b1;
          else if (cpu_req) gnt_cpu = 1'b1;
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  assign ctr_clr   = gnt_aux | ~aux_req;
  assign gnt_any   = gnt_cpu | gnt_aux;
  assign sel       = gnt_aux ? REQ_AUX : REQ_CPU;
  assign cpu_stall = cpu_req & ~gnt_cpu;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_any) begin
      if (sel == REQ_AUX) begin
        sel_we    = aux_we;
        sel_addr  = aux_addr;
        sel_wdata = aux_wdata;
      end else begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = gnt_any & sel_addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign mem_wr_en   = sel_we & ~misalign;
  assign mem_rd_addr = sel_addr;
  assign mem_wr_addr = sel_addr;
  assign mem_wdata   = sel_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack   <= 1'b0;
      aux_ack   <= 1'b0;
      cpu_rdata <= '0;
      aux_rdata <= '0;
    end else begin
      cpu_ack <= gnt_cpu;
      aux_ack <= gnt_aux;
      if (gnt_cpu && !cpu_we && !misalign) cpu_rdata <= mem_rdata;
      if (gnt_aux && !aux_we && !misalign) aux_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= misalign;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AUX_MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_ack, aux_ack, cpu_stall, mem_wr_en, err;
  logic [15:0] cpu_rdata, aux_rdata, mem_rd_addr, mem_wr_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .AUX_MAX_WAIT(AUX_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  // initial memory contents; word at 0x0008 is 0x000C
  function automatic logic [7:0] pat(input int i);
    logic [15:0] a;
    a = i[15:0];
    if (a == 16'h0008) return 8'h00;
    if (a == 16'h0009) return 8'h0C;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // byte-addressed big-endian memory attached to the DUT
  logic [7:0]  tb_mem [65536];
  logic        init_fill = 1'b0;
  logic [15:0] rd_a1, wr_a1;
  assign rd_a1     = mem_rd_addr + 16'd1;
  assign wr_a1     = mem_wr_addr + 16'd1;
  assign mem_rdata = {tb_mem[mem_rd_addr], tb_mem[rd_a1]};

  always @(posedge clk) begin
    if (init_fill) begin
      for (int i = 0; i < 65536; i++) tb_mem[i] <= pat(i);
    end else if (mem_wr_en) begin
      tb_mem[mem_wr_addr] <= mem_wdata[15:8];
      tb_mem[wr_a1]       <= mem_wdata[7:0];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [65536];
  int          streak;            // consecutive cycles AUX has been refused
  logic        exp_cpu_ack, exp_aux_ack, exp_err;
  logic [15:0] exp_cpu_rd, exp_aux_rd;
  logic        last_gc, last_ga;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {ref_mem[a], ref_mem[a1]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    ref_mem[a]  = d[15:8];
    ref_mem[a1] = d[7:0];
  endtask

  function automatic logic is_mis(input logic [15:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return a[0];
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1 with inputs already driven; checks the combinational
  // side, then the registered results one edge later.
  task automatic run_cycle();
    logic gc, ga, w, mis;
    logic [15:0] a, wd;
    #1;
    ga = aux_req && ((streak >= AUX_MAX_WAIT) || !cpu_req);
    gc = cpu_req && !ga;
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !gc});
    w = 1'b0; mis = 1'b0; a = '0; wd = '0;
    if (gc || ga) begin
      a   = gc ? cpu_addr  : aux_addr;
      w   = gc ? cpu_we    : aux_we;
      wd  = gc ? cpu_wdata : aux_wdata;
      mis = is_mis(a);
      chk("mem_rd_addr", {16'd0, mem_rd_addr}, {16'd0, a});
      chk("mem_wr_addr", {16'd0, mem_wr_addr}, {16'd0, a});
      if (w && !mis) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
    end
    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, w && !mis});
    exp_cpu_ack = gc;
    exp_aux_ack = ga;
    exp_err     = (gc || ga) && mis;
    if (gc && !w && !mis) exp_cpu_rd = ref_read(a);
    if (ga && !w && !mis) exp_aux_rd = ref_read(a);
    if ((gc || ga) && w && !mis) ref_write(a, wd);
    streak  = (!aux_req || ga) ? 0 : streak + 1;
    last_gc = gc;
    last_ga = ga;
    @(posedge clk); #1;
    chk("cpu_ack",   {31'd0, cpu_ack},   {31'd0, exp_cpu_ack});
    chk("aux_ack",   {31'd0, aux_ack},   {31'd0, exp_aux_ack});
    chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_cpu_rd});
    chk("aux_rdata", {16'd0, aux_rdata}, {16'd0, exp_aux_rd});
    chk("err",       {31'd0, err},       {31'd0, exp_err});
  endtask

  task automatic drive_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_aux(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'(($urandom_range(0, 31) << 1) | 1);
      default: return 16'($urandom_range(0, 31) << 1);
    endcase
  endfunction

  // Holds both requests and checks that AUX wins exactly in every
  // (AUX_MAX_WAIT+1)-th cycle, starting from a zero wait count.
  task automatic starve_run(input string tag, input int ncyc);
    int ngnt;
    ngnt = 0;
    drive_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
    drive_aux(1'b1, 1'b0, 16'h0042, 16'h0);
    for (int i = 0; i < ncyc; i++) begin
      run_cycle();
      if (last_ga) begin
        ngnt++;
        chk({tag, "_pos"}, i % (AUX_MAX_WAIT + 1), AUX_MAX_WAIT);
      end
    end
    chk({tag, "_cnt"}, ngnt, ncyc / (AUX_MAX_WAIT + 1));
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 16'h0);
    run_cycle();
  endtask

  initial begin
    logic c_pend, a_pend;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    streak = 0;
    exp_cpu_ack = 0; exp_aux_ack = 0; exp_err = 0;
    exp_cpu_rd = '0; exp_aux_rd = '0;
    last_gc = 0; last_ga = 0;
    rst = 1'b0;
    drive_cpu(1'b1, 1'b1, 16'h0050, 16'h1111);
    drive_aux(1'b1, 1'b1, 16'h0052, 16'h2222);
    init_fill = 1'b1;
    #1;
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_rd_addr", {16'd0, mem_rd_addr}, 32'd0);
    @(posedge clk); #1;
    init_fill = 1'b0;
    @(posedge clk); #1;
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_aux_ack", {31'd0, aux_ack}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_aux_rdata", {16'd0, aux_rdata}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_unwritten", {24'd0, tb_mem[16'h0050]}, {24'd0, pat(16'h0050)});
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;

    // 1: CPU read of preloaded word
    drive_cpu(1'b1, 1'b0, 16'h0008, 16'h0);
    run_cycle();
    chk("t1_rdata", {16'd0, cpu_rdata}, 32'h000C);
    chk("t1_ack", {31'd0, cpu_ack}, 32'd1);

    // 2: write then read back, ack on both cycles
    drive_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    run_cycle();
    chk("t2_wr_ack", {31'd0, cpu_ack}, 32'd1);
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    run_cycle();
    chk("t2_rd_ack", {31'd0, cpu_ack}, 32'd1);
    chk("t2_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    run_cycle();

    // 3: continuous contention
    starve_run("t3", 25);

    // 4: CPU write and AUX read of the same word in the same cycle
    drive_cpu(1'b1, 1'b1, 16'h0020, 16'h1234);
    drive_aux(1'b1, 1'b0, 16'h0020, 16'h0);
    run_cycle();
    chk("t4_cpu_first", {30'd0, cpu_ack, aux_ack}, 32'b10);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    run_cycle();
    chk("t4_aux_rdata", {16'd0, aux_rdata}, 32'h1234);
    drive_aux(1'b0, 1'b0, 16'h0, 16'h0);
    run_cycle();

    // 6: odd-address write
    drive_cpu(1'b1, 1'b1, 16'h0009, 16'h5A5A);
    run_cycle();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_mem", {24'd0, tb_mem[16'h0009]}, 32'h0C);
`else
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_mem", {24'd0, tb_mem[16'h0009]}, 32'h5A);
`endif
    chk("t6_ack", {31'd0, cpu_ack}, 32'd1);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    run_cycle();

    // 5: reset asserted during a granted write
    drive_aux(1'b1, 1'b1, 16'h0044, 16'h7777);
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    run_cycle();                       // CPU read, AUX denied once
    drive_cpu(1'b1, 1'b1, 16'h0030, 16'hAAAA);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("t5_ack_clr", {31'd0, cpu_ack}, 32'd0);
    chk("t5_rdata_clr", {16'd0, cpu_rdata}, 32'd0);
    @(posedge clk); #1;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    chk("t5_no_write", {16'd0, tb_mem[16'h0030], tb_mem[16'h0031]}, {16'd0, ref_read(16'h0030)});
    chk("t5_no_aux_write", {16'd0, tb_mem[16'h0044], tb_mem[16'h0045]}, {16'd0, ref_read(16'h0044)});
    streak = 0;
    exp_cpu_rd = '0; exp_aux_rd = '0;
    run_cycle();
    starve_run("t5_starve", 10);

    // random traffic following the request/ack handshake
    c_pend = 1'b0; a_pend = 1'b0;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_aux(1'b0, 1'b0, 16'h0, 16'h0);
    for (int n = 0; n < 400; n++) begin
      if (!c_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          c_pend = 1'b1;
          drive_cpu(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end else begin
          cpu_req = 1'b0;
        end
      end
      if (!a_pend) begin
        if ($urandom_range(0, 1) != 0) begin
          a_pend = 1'b1;
          drive_aux(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end else begin
          aux_req = 1'b0;
        end
      end
      run_cycle();
      if (last_gc) c_pend = 1'b0;
      if (last_ga) a_pend = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
